seq_mul_param: RTL and testbench

Parametrised radix-2 shift-add sequential multiplier; successor to the fixed 64-bit unsigned unit. Adds a generic operand width and RISC-V M-extension modes (MUL, MULH, MULHSU, MULHU). Adds a start/busy/done handshake and deterministic latency. Sits beside the ALU in the execute stage; the pipeline stalls while busy is high.

---
 rtl/seq_mul_pkg.sv | 28 ++
 rtl/seq_mul_core.sv | 52 +++++
 rtl/seq_mul_param.sv | 118 +++++++++++
 tb/tb_seq_mul_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared mode and state encodings for the sequential multiplier.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package seq_mul_pkg;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULH   = 2'b01;
    localparam logic [1:0] MODE_MULHSU = 2'b10;
    localparam logic [1:0] MODE_MULHU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic a_is_signed(input logic [1:0] mode);
        return (mode == MODE_MULH) || (mode == MODE_MULHSU);
    endfunction

    function automatic logic b_is_signed(input logic [1:0] mode);
        return (mode == MODE_MULH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_core
// Description : Unsigned radix-2 shift-add datapath: accumulator, adder, counter.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module seq_mul_core
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               last,
    output logic [2*WIDTH-1:0] acc
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_a;
    logic [2*WIDTH:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_sum;

    // {carry, hi} is summed as one WIDTH+1 bit quantity so the carry-out is never lost
    assign w_sum = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_a   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_a   <= a_mag;
            r_acc <= {1'b0, {WIDTH{1'b0}}, b_mag};
            r_cnt <= '0;
        end else if (step) begin
            r_acc <= {1'b0, w_sum, r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign last = (r_cnt == c_last);
    assign acc  = r_acc[2*WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_mul_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_param
// Description : Parametrised sequential multiplier with RISC-V M-extension modes.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module seq_mul_param
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [1:0]         r_mode;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_fix;
    logic               w_last;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Negating the most-negative value yields 2^(WIDTH-1), which is its correct magnitude
    assign w_sa    = a_is_signed(mode) & multiplicand[WIDTH-1];
    assign w_sb    = b_is_signed(mode) & multiplier[WIDTH-1];
    assign w_a_mag = w_sa ? -multiplicand : multiplicand;
    assign w_b_mag = w_sb ? -multiplier   : multiplier;

    seq_mul_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (w_load),
        .step  (w_step),
        .a_mag (w_a_mag),
        .b_mag (w_b_mag),
        .last  (w_last),
        .acc   (w_acc)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (w_last)   w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state == S_CALC) || (r_state == S_FIX);
        done   = (r_state == S_DONE);
        w_load = w_accept;
        w_step = (r_state == S_CALC);
        w_fix  = (r_state == S_FIX);
    end

    assign w_prod = r_neg ? -w_acc : w_acc;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mode    <= MODE_MUL;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_result  <= '0;
        end else begin
            if (w_load) begin
                r_mode <= mode;
                r_neg  <= w_sa ^ w_sb;
            end
            if (w_fix) begin
                r_product <= w_prod;
                r_result  <= (r_mode == MODE_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign product = r_product;
    assign result  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul_param
// Description : Self-checking bench for seq_mul_param at WIDTH 8, 32 and 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul_param;

    localparam logic [1:0] M_MUL    = 2'b00;
    localparam logic [1:0] M_MULH   = 2'b01;
    localparam logic [1:0] M_MULHSU = 2'b10;
    localparam logic [1:0] M_MULHU  = 2'b11;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [2:0]  st;
    logic [1:0]  mode;
    logic [63:0] opa;
    logic [63:0] opb;

    logic         b8, d8, b32, d32, b64, d64;
    logic [15:0]  p8;
    logic [7:0]   r8;
    logic [63:0]  p32;
    logic [31:0]  r32;
    logic [127:0] p64;
    logic [63:0]  r64;

    int           sel;
    logic         busy_s;
    logic         done_s;
    logic [127:0] prod_s;
    logic [127:0] res_s;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    seq_mul_param #(.WIDTH(8)) u_dut8 (
        .Clk(Clk), .Rst(Rst), .start(st[0]), .mode(mode),
        .multiplicand(opa[7:0]), .multiplier(opb[7:0]),
        .busy(b8), .done(d8), .product(p8), .result(r8)
    );

    seq_mul_param #(.WIDTH(32)) u_dut32 (
        .Clk(Clk), .Rst(Rst), .start(st[1]), .mode(mode),
        .multiplicand(opa[31:0]), .multiplier(opb[31:0]),
        .busy(b32), .done(d32), .product(p32), .result(r32)
    );

    seq_mul_param #(.WIDTH(64)) u_dut64 (
        .Clk(Clk), .Rst(Rst), .start(st[2]), .mode(mode),
        .multiplicand(opa), .multiplier(opb),
        .busy(b64), .done(d64), .product(p64), .result(r64)
    );

    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        prod_s = '0;
        res_s  = '0;
        case (sel)
            0: begin busy_s = b8;  done_s = d8;  prod_s = 128'(p8);  res_s = 128'(r8);  end
            1: begin busy_s = b32; done_s = d32; prod_s = 128'(p32); res_s = 128'(r32); end
            2: begin busy_s = b64; done_s = d64; prod_s = p64;       res_s = 128'(r64); end
            default: ;
        endcase
    end

    function automatic int width_of(input int s);
        case (s)
            0:       return 8;
            1:       return 32;
            default: return 64;
        endcase
    endfunction

    // Reference: interpret operands as signed/unsigned integers and multiply exactly
    function automatic void ref_model(input int w, input logic [1:0] m,
                                      input logic [63:0] a_in, input logic [63:0] b_in,
                                      output logic [127:0] p, output logic [127:0] r);
        logic [63:0]         wmask;
        logic [63:0]         a;
        logic [63:0]         b;
        logic signed [129:0] sa;
        logic signed [129:0] sb;
        logic signed [129:0] pp;
        logic [129:0]        shifted;
        wmask = (64'd1 << w) - 64'd1;
        if (w == 64) wmask = '1;
        a  = a_in & wmask;
        b  = b_in & wmask;
        sa = $signed({66'd0, a});
        sb = $signed({66'd0, b});
        if ((m == M_MULH || m == M_MULHSU) && a[w-1]) sa = sa - $signed(130'd1 << w);
        if ((m == M_MULH) && b[w-1])                  sb = sb - $signed(130'd1 << w);
        pp      = sa * sb;
        p       = 128'(pp & ((130'd1 << (2*w)) - 130'd1));
        shifted = (m == M_MUL) ? pp : (pp >>> w);
        r       = 128'(shifted & ((130'd1 << w) - 130'd1));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse covering exactly one rising edge; returns #1 after it
    task automatic launch(input int s, input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
        sel    = s;
        mode   = m;
        opa    = a;
        opb    = b;
        st     = 3'b000;
        st[s]  = 1'b1;
        @(posedge Clk);
        #1 st  = 3'b000;
    endtask

    task automatic wait_done(input int w, output int n, output bit busy_ok);
        @(negedge Clk);
        n       = 0;
        busy_ok = 1'b1;
        while (!done_s && n < w + 5) begin
            if (!busy_s) busy_ok = 1'b0;
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic check_res(input string tag, input int s, input logic [1:0] m,
                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ep;
        logic [127:0] er;
        ref_model(width_of(s), m, a, b, ep, er);
        chk({tag, "_product"}, prod_s, ep);
        chk({tag, "_result"},  res_s,  er);
    endtask

    task automatic do_op(input string tag, input int s, input logic [1:0] m,
                         input logic [63:0] a, input logic [63:0] b);
        int n;
        bit busy_ok;
        @(negedge Clk);
        launch(s, m, a, b);
        wait_done(width_of(s), n, busy_ok);
        chk({tag, "_latency"}, 128'(n), 128'(width_of(s) + 1));
        chk({tag, "_busy_run"}, 128'(busy_ok), 128'(1));
        chk({tag, "_busy_at_done"}, 128'(busy_s), 128'(0));
        check_res(tag, s, m, a, b);
        @(negedge Clk);
        chk({tag, "_done_pulse"}, 128'(done_s), 128'(0));
    endtask

    initial begin
        int          n;
        int          seen;
        bit          busy_ok;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] wmask;

        Rst  = 1'b1;
        st   = 3'b000;
        mode = M_MUL;
        opa  = '0;
        opb  = '0;
        sel  = 0;
        repeat (3) @(posedge Clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_busy",    128'(busy_s), 128'(0));
            chk("reset_done",    128'(done_s), 128'(0));
            chk("reset_product", prod_s, 128'(0));
            chk("reset_result",  res_s,  128'(0));
        end
        Rst = 1'b0;

        do_op("mulhu_max", 1, M_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        chk("mulhu_max_const_p", prod_s, 128'hFFFF_FFFE_0000_0001);
        chk("mulhu_max_const_r", res_s,  128'hFFFF_FFFE);

        do_op("mul_neg1x5", 1, M_MUL, 64'hFFFF_FFFF, 64'd5);
        chk("mul_neg1x5_const_r", res_s, 128'hFFFF_FFFB);

        do_op("mulh_minsq", 1, M_MULH, 64'h8000_0000, 64'h8000_0000);
        chk("mulh_minsq_const_p", prod_s, 128'h4000_0000_0000_0000);
        chk("mulh_minsq_const_r", res_s,  128'h4000_0000);

        do_op("mulhsu_neg1", 1, M_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        chk("mulhsu_neg1_const_p", prod_s, 128'hFFFF_FFFF_0000_0001);
        chk("mulhsu_neg1_const_r", res_s,  128'hFFFF_FFFF);

        // Second start at edge 10 must be ignored
        @(negedge Clk);
        launch(1, M_MUL, 64'd7, 64'd9);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        mode = M_MULHU;
        opa  = 64'h1234_5678;
        opb  = 64'h9ABC_DEF0;
        st   = 3'b010;
        @(posedge Clk);
        #1 st = 3'b000;
        wait_done(32, n, busy_ok);
        chk("ignore_latency", 128'(n + 10), 128'(33));
        chk("ignore_product", prod_s, 128'd63);
        chk("ignore_result",  res_s,  128'd63);

        // Start accepted in the DONE cycle
        launch(1, M_MULH, 64'hFFFF_FFFD, 64'd4);
        wait_done(32, n, busy_ok);
        chk("b2b_spacing", 128'(n + 1), 128'(34));
        check_res("b2b", 1, M_MULH, 64'hFFFF_FFFD, 64'd4);
        chk("b2b_const_p", prod_s, 128'hFFFF_FFFF_FFFF_FFF4);
        @(negedge Clk);

        // Reset at edge 15 abandons the operation
        @(negedge Clk);
        launch(1, M_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        repeat (14) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_busy",    128'(busy_s), 128'(0));
        chk("midrst_done",    128'(done_s), 128'(0));
        chk("midrst_product", prod_s, 128'(0));
        chk("midrst_result",  res_s,  128'(0));
        seen = 0;
        repeat (40) begin
            @(negedge Clk);
            if (done_s) seen++;
        end
        chk("midrst_no_done", 128'(seen), 128'(0));
        do_op("after_rst", 1, M_MULH, 64'h8000_0000, 64'h7FFF_FFFF);

        // Random regression per width and mode, with a few extreme operands first
        for (int s = 0; s < 3; s++) begin
            wmask = (width_of(s) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width_of(s)) - 64'd1);
            for (int m = 0; m < 4; m++) begin
                for (int i = 0; i < ((s == 0) ? 250 : (s == 1) ? 100 : 60); i++) begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                    case (i)
                        0: begin ra = '1; rb = '1; end
                        1: begin ra = 64'd1 << (width_of(s) - 1); rb = ra; end
                        2: begin ra = 64'd1 << (width_of(s) - 1); rb = '1; end
                        3: begin ra = '0; end
                        default: ;
                    endcase
                    do_op("rand", s, 2'(m), ra & wmask, rb & wmask);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
